// File: rtl/interface_botoes_pkg.sv
// Shared constants for the button interface: note count, empty-note code
// and the note FSM state encoding.
package interface_botoes_pkg;

    localparam int NUM_NOTAS = 12;
    localparam int NUM_MENU  = 3;
    localparam int NUM_TECLAS = NUM_NOTAS + NUM_MENU;

    typedef logic [3:0] nota_code_t;

    localparam nota_code_t NOTA_NENHUMA = 4'h0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

endpackage

// File: rtl/interface_botoes_debouncer.sv
// One key channel: 2-flop synchronizer, stability counter, accepted level
// and a single-cycle pulse on each accepted rising edge.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count,
            // so a glitch shorter than the window never gets through.
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_2;
                rise   <= sync_2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/interface_botoes.sv
// Button front end: debounces 12 note keys and 3 menu keys, latches the
// lowest pressed note until it is released, and emits menu press pulses.
module interface_botoes
    import interface_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] botoes,
    input  logic        right_arrow,
    input  logic        left_arrow,
    input  logic        enter,
    output logic [3:0]  botoes_encoded,
    output logic        right_arrow_pressed,
    output logic        left_arrow_pressed,
    output logic        enter_pressed,
    output logic        db_nota_travada
);

    logic [NUM_TECLAS-1:0] raw_all;
    logic [NUM_TECLAS-1:0] stable_all;
    logic [NUM_TECLAS-1:0] rise_all;

    assign raw_all = {enter, left_arrow, right_arrow, botoes};

    for (genvar i = 0; i < NUM_TECLAS; i++) begin : g_deb
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock (clock),
            .reset (reset),
            .raw   (raw_all[i]),
            .stable(stable_all[i]),
            .rise  (rise_all[i])
        );
    end

    logic [NUM_NOTAS-1:0] stable_notas;
    logic                 rise_right;
    logic                 rise_left;
    logic                 rise_enter;

    assign stable_notas = stable_all[NUM_NOTAS-1:0];
    assign rise_right   = rise_all[NUM_NOTAS];
    assign rise_left    = rise_all[NUM_NOTAS+1];
    assign rise_enter   = rise_all[NUM_NOTAS+2];

    // Note rise pulses and menu stable levels have no consumer here.
    logic unused_bits;
    assign unused_bits = ^{rise_all[NUM_NOTAS-1:0], stable_all[NUM_TECLAS-1:NUM_NOTAS]};

    // Lowest-index key wins when several notes are stable high.
    logic       any_nota;
    logic [3:0] first_idx;

    always_comb begin
        any_nota  = |stable_notas;
        first_idx = 4'd0;
        for (int i = NUM_NOTAS - 1; i >= 0; i--) begin
            if (stable_notas[i]) begin
                first_idx = 4'(i);
            end
        end
    end

    logic [0:0] state;
    logic [3:0] nota_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            nota_idx       <= 4'd0;
            botoes_encoded <= NOTA_NENHUMA;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_nota) begin
                        nota_idx       <= first_idx;
                        botoes_encoded <= first_idx + 4'd1;
                        state          <= ST_HELD;
                    end else begin
                        botoes_encoded <= NOTA_NENHUMA;
                    end
                end
                ST_HELD: begin
                    // Only the latched key matters; others are re-evaluated in IDLE.
                    if (!stable_notas[nota_idx]) begin
                        botoes_encoded <= NOTA_NENHUMA;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    botoes_encoded <= NOTA_NENHUMA;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

    assign db_nota_travada = (state == ST_HELD);

    // Simultaneous arrow edges are ambiguous, so neither is reported.
    assign right_arrow_pressed = rise_right & ~rise_left;
    assign left_arrow_pressed  = rise_left & ~rise_right;
    assign enter_pressed       = rise_enter;

endmodule

// File: tb/tb_interface_botoes.sv
// Directed bench for interface_botoes with DEBOUNCE_CYCLES = 4: stimulus
// pushes timestamped expected output events, a negedge monitor pops them.
module tb_interface_botoes;

    localparam int DB        = 4;
    localparam int LAT_PULSE = DB + 2;
    localparam int LAT_CODE  = DB + 3;

    localparam logic [3:0] K_CODE  = 4'd0;
    localparam logic [3:0] K_RIGHT = 4'd1;
    localparam logic [3:0] K_LEFT  = 4'd2;
    localparam logic [3:0] K_ENTER = 4'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] botoes = '0;
    logic        right_arrow = 1'b0;
    logic        left_arrow = 1'b0;
    logic        enter = 1'b0;
    logic [3:0]  botoes_encoded;
    logic        right_arrow_pressed;
    logic        left_arrow_pressed;
    logic        enter_pressed;
    logic        db_nota_travada;

    int          cyc = 0;
    int          n_compared = 0;
    int          n_mismatch = 0;
    logic        mon_en = 1'b0;
    logic [3:0]  prev_code = 4'd0;
    logic [31:0] exp_q[$];

    interface_botoes #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .botoes             (botoes),
        .right_arrow        (right_arrow),
        .left_arrow         (left_arrow),
        .enter              (enter),
        .botoes_encoded     (botoes_encoded),
        .right_arrow_pressed(right_arrow_pressed),
        .left_arrow_pressed (left_arrow_pressed),
        .enter_pressed      (enter_pressed),
        .db_nota_travada    (db_nota_travada)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] pack_ev(input int c, input logic [3:0] kind, input logic [3:0] val);
        logic [31:0] cw;
        cw = c;
        return {cw[23:0], kind, val};
    endfunction

    function automatic void push_ev(input int c, input logic [3:0] kind, input logic [3:0] val);
        exp_q.push_back(pack_ev(c, kind, val));
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatch++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor
    task automatic observe(input logic [31:0] got);
        logic [31:0] want;
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatch++;
            $display("FAIL unexpected_event: got cyc=%0d kind=%0d val=%0d, expected none",
                     got[31:8], got[7:4], got[3:0]);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_mismatch++;
                $display("FAIL event: got cyc=%0d kind=%0d val=%0d, expected cyc=%0d kind=%0d val=%0d",
                         got[31:8], got[7:4], got[3:0], want[31:8], want[7:4], want[3:0]);
            end
            if (want[7:4] == K_CODE) begin
                check("db_nota_travada", {3'b0, db_nota_travada}, {3'b0, (want[3:0] != 4'd0)});
            end
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (botoes_encoded !== prev_code) begin
                observe(pack_ev(cyc, K_CODE, botoes_encoded));
                prev_code = botoes_encoded;
            end
            if (right_arrow_pressed) observe(pack_ev(cyc, K_RIGHT, 4'd1));
            if (left_arrow_pressed)  observe(pack_ev(cyc, K_LEFT, 4'd1));
            if (enter_pressed)       observe(pack_ev(cyc, K_ENTER, 4'd1));
        end
    end

    initial begin
        logic [31:0] left_over;
        #1 reset = 1'b1;
        step(3);
        check("reset_code", botoes_encoded, 4'd0);
        check("reset_db", {3'b0, db_nota_travada}, 4'd0);
        check("reset_pulses", {1'b0, right_arrow_pressed, left_arrow_pressed, enter_pressed}, 4'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Single note: key 5 encodes as 6, release back to 0 with the same latency
        botoes[5] = 1'b1;
        push_ev(cyc + LAT_CODE, K_CODE, 4'd6);
        step(12);
        botoes[5] = 1'b0;
        push_ev(cyc + LAT_CODE, K_CODE, 4'd0);
        step(12);

        // Two notes: lowest wins, stays latched, re-press after one zero cycle
        botoes[3] = 1'b1;
        botoes[9] = 1'b1;
        push_ev(cyc + LAT_CODE, K_CODE, 4'd4);
        step(12);
        botoes[9] = 1'b0;
        step(12);
        botoes[9] = 1'b1;
        step(12);
        botoes[3] = 1'b0;
        push_ev(cyc + LAT_CODE, K_CODE, 4'd0);
        push_ev(cyc + LAT_CODE + 1, K_CODE, 4'd10);
        step(12);
        botoes[9] = 1'b0;
        push_ev(cyc + LAT_CODE, K_CODE, 4'd0);
        step(12);

        // Enter: short blip ignored, long press gives one pulse
        enter = 1'b1;
        step(2);
        enter = 1'b0;
        step(12);
        enter = 1'b1;
        push_ev(cyc + LAT_PULSE, K_ENTER, 4'd1);
        step(20);
        enter = 1'b0;
        step(12);

        // Arrows together suppressed, then each alone
        right_arrow = 1'b1;
        left_arrow  = 1'b1;
        step(12);
        right_arrow = 1'b0;
        left_arrow  = 1'b0;
        step(12);
        right_arrow = 1'b1;
        push_ev(cyc + LAT_PULSE, K_RIGHT, 4'd1);
        step(10);
        right_arrow = 1'b0;
        step(12);
        left_arrow = 1'b1;
        push_ev(cyc + LAT_PULSE, K_LEFT, 4'd1);
        step(10);
        left_arrow = 1'b0;
        step(12);

        // Reset while key 0 is held, key kept high through deassertion
        botoes[0] = 1'b1;
        push_ev(cyc + LAT_CODE, K_CODE, 4'd1);
        step(12);
        push_ev(cyc, K_CODE, 4'd0);
        reset = 1'b1;
        #1;
        check("async_reset_code", botoes_encoded, 4'd0);
        check("async_reset_db", {3'b0, db_nota_travada}, 4'd0);
        step(3);
        reset = 1'b0;
        push_ev(cyc + LAT_CODE, K_CODE, 4'd1);
        step(12);
        botoes[0] = 1'b0;
        push_ev(cyc + LAT_CODE, K_CODE, 4'd0);
        step(12);

        // Bouncing key 2: 3-cycle segments never settle
        for (int i = 0; i < 17; i++) begin
            botoes[2] = ~botoes[2];
            step(3);
        end
        botoes[2] = 1'b0;
        step(12);

        step(5);
        while (exp_q.size() > 0) begin
            left_over = exp_q.pop_front();
            n_compared++;
            n_mismatch++;
            $display("FAIL missing_event: got nothing, expected cyc=%0d kind=%0d val=%0d",
                     left_over[31:8], left_over[7:4], left_over[3:0]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
